// File: rtl/data_count_ctrl.sv
// Multi-channel terminal counter with a run/done controller.
// Each channel counts enabled increments up to a shared terminal value latched at start,
// and either wraps to zero or stops there. The controller leaves RUN once every channel has
// reached the terminal value.

// One counter channel. Holds the count, the "terminal seen" flag and the terminal pulse.
module data_count_lane #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic             run_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             hit_o,
  output logic             tc_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d, nxt;
  logic             hit_q, hit_d, tc_q, tc_d, at_term, accept;

  assign at_term = (cnt_q == term_i);
  // In stop mode an increment arriving at the terminal value is dropped.
  assign accept  = en_i && !(mode_i && at_term);
  // Wrap mode goes from the terminal value back to zero; otherwise add one modulo 2^WIDTH.
  assign nxt     = at_term ? '0 : cnt_q + 1'b1;

  // Next state: clr beats start, and start beats increments.
  always_comb begin
    cnt_d = cnt_q;
    hit_d = hit_q;
    tc_d  = 1'b0;
    if (clr_i || start_i) begin
      cnt_d = '0;
      hit_d = 1'b0;
    end else if (run_i) begin
      if (at_term) hit_d = 1'b1;
      if (accept) begin
        cnt_d = nxt;
        tc_d  = (nxt == term_i);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = hit_q;
  assign tc_o  = tc_q;
endmodule

module data_count_ctrl #(
  parameter int WIDTH = 3,
  parameter int CH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                start_i,
  input  logic [CH-1:0]       en_i,
  input  logic [WIDTH-1:0]    term_val_i,
  input  logic                mode_i,
  output logic [CH*WIDTH-1:0] count_o,
  output logic [CH-1:0]       co_o,
  output logic [CH-1:0]       tc_pulse_o,
  output logic                busy_o,
  output logic                done_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                     state_q, state_d;
  logic [WIDTH-1:0]           term_q, term_d;
  logic                       mode_q, mode_d;
  logic [CH-1:0][WIDTH-1:0]   cnt;
  logic [CH-1:0]              hit;
  logic                       run;

  assign run = (state_q == RUN);

  // Next state and terminal/mode latching.
  always_comb begin
    state_d = state_q;
    term_d  = term_q;
    mode_d  = mode_q;
    if (clr_i) begin
      state_d = IDLE;
      term_d  = '0;
      mode_d  = 1'b0;
    end else if (start_i) begin
      state_d = RUN;
      term_d  = term_val_i;
      mode_d  = mode_i;
    end else if (run && (&hit)) begin
      state_d = DONE;
    end
  end

  // Controller registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      term_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    data_count_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr_i),
      .start_i (start_i),
      .run_i   (run),
      .en_i    (en_i[i]),
      .term_i  (term_q),
      .mode_i  (mode_q),
      .cnt_o   (cnt[i]),
      .hit_o   (hit[i]),
      .tc_o    (tc_pulse_o[i])
    );
    // The terminal flag is only meaningful once a run has been started.
    assign co_o[i] = (cnt[i] == term_q) && (state_q != IDLE);
  end

  assign count_o = cnt;
  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);
endmodule

// File: tb/tb_data_count_ctrl.sv
// Directed bench for data_count_ctrl (WIDTH=3, CH=2).
module tb_data_count_ctrl;
  logic       clk = 1'b0;
  logic       rst, clr, start, mode;
  logic [1:0] en;
  logic [2:0] term;
  logic [5:0] count;
  logic [1:0] co, tc;
  logic       busy, done;
  int tests = 0;
  int fails = 0;

  data_count_ctrl #(.WIDTH(3), .CH(2)) dut (
    .clk(clk), .rst(rst), .clr_i(clr), .start_i(start), .en_i(en),
    .term_val_i(term), .mode_i(mode), .count_o(count), .co_o(co),
    .tc_pulse_o(tc), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [2:0] t, input logic m, input logic [1:0] e);
    start = 1'b1; term = t; mode = m; en = e;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; start = 1'b1; en = 2'b11; term = 3'd5; mode = 1'b1;
    step(); step();
    tests++; if (count !== 6'd0) begin fails++; $display("FAIL reset_count got=%h exp=0", count); end
    tests++; if ({busy, done, tc, co} !== 6'b0) begin fails++; $display("FAIL reset_flags got=%b exp=0", {busy, done, tc, co}); end
    start = 1'b0; en = 2'b00;
    rst = 1'b0;
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_stop_mode();
    logic [2:0] e;
    do_start(3'd5, 1'b1, 2'b00);
    tests++; if ({busy, count} !== {1'b1, 6'd0}) begin fails++; $display("FAIL stop_start got=%b/%h", busy, count); end
    en = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      step();
      e = (k < 5) ? 3'(k) : 3'd5;
      tests++; if (count !== {e, e}) begin fails++; $display("FAIL stop_count k=%0d got=%h exp=%h", k, count, {e, e}); end
      tests++; if (tc !== ((k == 5) ? 2'b11 : 2'b00)) begin fails++; $display("FAIL stop_tc k=%0d got=%b", k, tc); end
      tests++; if (done !== (k == 7)) begin fails++; $display("FAIL stop_done k=%0d got=%b", k, done); end
    end
    tests++; if (co !== 2'b11) begin fails++; $display("FAIL stop_co got=%b exp=11", co); end
    step();
    tests++; if ({done, busy, tc, count} !== {1'b1, 1'b0, 2'b00, 6'o55}) begin fails++; $display("FAIL stop_hold got=%b %b %b %h", done, busy, tc, count); end
    en = 2'b00;
  endtask

  task automatic test_wrap();
    do_start(3'd3, 1'b0, 2'b00);
    en = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      step();
      tests++; if (count !== {3'd0, 3'(k % 4)}) begin fails++; $display("FAIL wrap_count k=%0d got=%h exp=%0d", k, count, k % 4); end
      tests++; if (tc !== ((k == 3 || k == 7) ? 2'b01 : 2'b00)) begin fails++; $display("FAIL wrap_tc k=%0d got=%b", k, tc); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL wrap_done_early k=%0d got=%b", k, done); end
    end
    en = 2'b10;
    step(); step(); step();
    tests++; if ({count, tc} !== {6'o31, 2'b10}) begin fails++; $display("FAIL wrap_ch1 got=%h %b exp=31 10", count, tc); end
    en = 2'b00;
    step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL wrap_done_hit got=%b exp=0", done); end
    step();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL wrap_done got=%b exp=1", done); end
  endtask

  task automatic test_wrap7();
    do_start(3'd7, 1'b0, 2'b00);
    en = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      step();
      tests++; if (count[2:0] !== 3'(k % 8)) begin fails++; $display("FAIL w7_count k=%0d got=%0d exp=%0d", k, count[2:0], k % 8); end
      tests++; if (tc[0] !== (k == 7)) begin fails++; $display("FAIL w7_tc k=%0d got=%b", k, tc[0]); end
    end
    en = 2'b00;
  endtask

  task automatic test_clr_start();
    do_start(3'd5, 1'b1, 2'b00);
    en = 2'b11;
    step(); step();
    tests++; if (count !== 6'o22) begin fails++; $display("FAIL cs_pre got=%h exp=12", count); end
    start = 1'b1; clr = 1'b1;
    step();
    start = 1'b0; clr = 1'b0;
    tests++; if ({busy, done, count, co} !== 10'b0) begin fails++; $display("FAIL cs_clr got=%b %b %h %b", busy, done, count, co); end
    step();
    tests++; if (count !== 6'd0) begin fails++; $display("FAIL cs_idle_en got=%h exp=0", count); end
    do_start(3'd5, 1'b1, 2'b11);
    tests++; if ({busy, count} !== {1'b1, 6'd0}) begin fails++; $display("FAIL cs_start_en got=%b %h", busy, count); end
    en = 2'b00; clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_async_rst();
    do_start(3'd6, 1'b0, 2'b00);
    en = 2'b11;
    step(); step();
    en = 2'b10;
    step(); step();
    tests++; if (count !== 6'o42) begin fails++; $display("FAIL ar_pre got=%h exp=22", count); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({count, busy, done, tc, co} !== 12'b0) begin fails++; $display("FAIL ar_async got=%h %b %b %b %b", count, busy, done, tc, co); end
    en = 2'b11;
    step();
    rst = 1'b0;
    step();
    tests++; if ({count, busy, tc} !== 9'b0) begin fails++; $display("FAIL ar_after got=%h %b %b", count, busy, tc); end
    en = 2'b00;
  endtask

  task automatic test_term0();
    do_start(3'd0, 1'b1, 2'b11);
    tests++; if (co !== 2'b11) begin fails++; $display("FAIL t0_co got=%b exp=11", co); end
    step();
    tests++; if ({done, count, tc} !== 9'b0) begin fails++; $display("FAIL t0_c1 got=%b %h %b", done, count, tc); end
    step();
    tests++; if ({done, count} !== {1'b1, 6'd0}) begin fails++; $display("FAIL t0_done got=%b %h", done, count); end
    do_start(3'd0, 1'b0, 2'b00);
    en = 2'b01;
    step();
    tests++; if ({tc, count} !== {2'b01, 6'd0}) begin fails++; $display("FAIL t0_wrap got=%b %h exp=01 0", tc, count); end
    step();
    tests++; if (tc !== 2'b01) begin fails++; $display("FAIL t0_wrap2 got=%b exp=01", tc); end
    en = 2'b00;
  endtask

  initial begin
    test_reset();
    test_stop_mode();
    test_wrap();
    test_wrap7();
    test_clr_start();
    test_async_rst();
    test_term0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_count_ctrl.md
DATA_COUNT_CTRL -- requirements
Module: data_count_ctrl

Interface
REQ-001 Parameter WIDTH, default 3, bit width of each channel counter and of the terminal value.
REQ-002 Parameter CH, default 2, number of independent counter channels (CH >= 1).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous clear; returns block to IDLE, zeroes all state.
REQ-006 start  input  1  begin a counting run; latches term_val and mode.
REQ-007 en  input  CH  per-channel increment request; bit i increments channel i.
REQ-008 term_val  input  WIDTH  terminal count, sampled only on accepted start.
REQ-009 mode  input  1  0 = wrap (terminal -> 0 on next increment), 1 = stop (hold at terminal); sampled with start.
REQ-010 count  output  CH*WIDTH  channel counts, channel i at bits [i*WIDTH +: WIDTH].
REQ-011 co  output  CH  combinational level, co[i] = 1 when count[i] == latched terminal and state != IDLE.
REQ-012 tc_pulse  output  CH  registered one-cycle terminal pulse per channel.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  high in DONE.

Function
REQ-015 Three-state FSM: IDLE, RUN, DONE; registered state, encoding free.
REQ-016 Priority per cycle: clr > start > en.
REQ-017 clr in any state -> next state IDLE; counts, hit flags, tc_pulse, latched term and mode cleared to 0.
REQ-018 start (clr low) in any state -> next state RUN; counts cleared to 0; term_val and mode latched; hit flags cleared; en ignored that cycle.
REQ-019 IDLE: en ignored, counts hold.
REQ-020 RUN: increment accepted for channel i when en[i]=1, except in stop mode with count[i] == term (increment dropped, count holds).
REQ-021 Accepted increment, wrap mode: count[i] == term -> 0; otherwise count[i]+1, modulo 2^WIDTH.
REQ-022 Accepted increment, stop mode: count[i]+1 (never exceeds term).
REQ-023 tc_pulse[i] = 1 for exactly the cycle after an accepted increment whose result equals term; 0 otherwise.
REQ-024 Wrap mode with term = 0: count stays 0, every accepted en[i] yields a tc_pulse[i].
REQ-025 hit[i] (internal) sets on any RUN cycle where count[i] == term; cleared only by start, clr or rst.
REQ-026 RUN -> DONE on the cycle after all hit bits are 1; stop mode with term = 0 reaches DONE two cycles after start.
REQ-027 DONE: counts hold, en ignored, tc_pulse 0; exited only by start or clr.
REQ-028 Channels independent; simultaneous en on multiple channels all accepted in the same cycle.
REQ-029 count, tc_pulse, busy, done are registered or state-decoded only; no combinational path from en to any output except through co.

Reset
REQ-030 rst asserted -> immediately state IDLE, count = 0, tc_pulse = 0, hit = 0, latched term = 0, mode = 0, busy = 0, done = 0.
REQ-031 rst dominates clr and start; first active edge after rst release is evaluated normally.
REQ-032 rst mid-run discards all progress; no tc_pulse is generated by the reset itself.

Verification
REQ-033 WIDTH=3, CH=2: start with term=5, mode=1; en=2'b11 for 7 cycles -> both counts 0..5 then hold at 5; tc_pulse=2'b11 once; co=2'b11; done=1 the cycle after hit completes.
REQ-034 mode=0, term=3, en[0] held 9 cycles -> count[0] sequence 1,2,3,0,1,2,3,0,1; tc_pulse[0] after the 3rd and 7th increments; done only after channel 1 also reaches 3.
REQ-035 term=7, mode=0, WIDTH=3: count wraps 7 -> 0 without overflow error; tc_pulse on reaching 7.
REQ-036 start and clr asserted together in RUN -> IDLE, counts 0, busy=0; start with en=all ones -> counts 0 after that edge.
REQ-037 rst pulsed asynchronously mid-RUN (counts 2 and 4) -> outputs zero before the next clk edge; no tc_pulse afterwards.
REQ-038 Stop mode, term=0 -> co=all ones after start, done=1 two cycles after start, en has no effect.
